// File: rtl/count_game_pkg.sv
// Shared types and constants for the count_game sequencer.
package count_game_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, PAUSE, DONE} state_t;

  localparam logic [2:0] BLANK_CODE = 3'd7;
  localparam logic [2:0] MAX_DIGIT  = 3'd6;

endpackage

// File: rtl/count_game_ctrl_key_debounce.sv
// Per-key 2-flop synchronizer, stable-sample debouncer and rising-edge pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  // cnt counts consecutive synchronized samples that disagree with level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        pulse <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/count_game_ctrl.sv
// count_game sequencer: debounced start/pause keys, 1 Hz countdown, digit code out.
// Define COUNT_GAME_BLINK_EN to blink the final 0 in DONE every BLINK_DIV cycles.
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int START_VAL  = 6,
  parameter int DEB_CYCLES = 20,
  parameter int BLINK_DIV  = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_pause,
  output logic [2:0] num,
  output logic       busy,
  output logic       done,
  output logic       step
);

  localparam int         TW          = $clog2(TICK_DIV);
  localparam logic [2:0] START_DIGIT = (START_VAL > int'(MAX_DIGIT)) ? MAX_DIGIT : 3'(START_VAL);

  state_t        state;
  logic [2:0]    digit;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    key_p;   // [0] start, [1] pause

`ifdef COUNT_GAME_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
`endif

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_deb [1:0] (
    .clk   (clk),
    .rst   (rst),
    .key   ({key_pause, key_start}),
    .pulse (key_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      digit    <= START_DIGIT;
      tick_cnt <= '0;
      num      <= BLANK_CODE;
      busy     <= 1'b0;
      done     <= 1'b0;
      step     <= 1'b0;
`ifdef COUNT_GAME_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      step <= 1'b0;
      // start wins over pause and restarts the game from any state
      if (key_p[0]) begin
        state    <= COUNT;
        digit    <= START_DIGIT;
        tick_cnt <= '0;
        num      <= START_DIGIT;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        case (state)
          COUNT: begin
            if (key_p[1]) begin
              state <= PAUSE;
            end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
              tick_cnt <= '0;
              step     <= 1'b1;
              if (digit != 3'd0) begin
                digit <= digit - 3'd1;
                num   <= digit - 3'd1;
              end else begin
                state <= DONE;
                num   <= 3'd0;
                busy  <= 1'b0;
                done  <= 1'b1;
`ifdef COUNT_GAME_BLINK_EN
                blink_cnt <= '0;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          PAUSE: begin
            if (key_p[1]) state <= COUNT;
          end
          DONE: begin
`ifdef COUNT_GAME_BLINK_EN
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
              blink_cnt <= '0;
              num       <= (num == BLANK_CODE) ? 3'd0 : BLANK_CODE;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/count_game_ctrl.md
# count_game_ctrl

Game sequencer for the count_game dot-matrix display. Debounces the start and pause keys, runs a once-per-second countdown from START_VAL to 0, and drives the 3-bit digit code consumed by the 8x8 dot-matrix row-scan driver. Codes 0–6 are digits; code 7 is blank. Sits between the board keys and the display driver, in the same 1 kHz clock domain.

## Interface
Parameters:
- TICK_DIV, 1000: clk cycles per countdown step (1 s at 1 kHz); must be ≥2.
- START_VAL, 6: first digit shown; legal range 0–6.
- DEB_CYCLES, 20: consecutive stable synchronized samples required to accept a key level.
- BLINK_DIV, 250: half-period of the end-of-game blink, in clk cycles (used only with the blink macro).

Ports:
- clk  in  1  1 kHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- key_start  in  1  raw start key, active-high, asynchronous to clk.
- key_pause  in  1  raw pause key, active-high, asynchronous to clk.
- num  out  3  digit code to the display driver; 7 = blank.
- busy  out  1  high in COUNT and PAUSE.
- done  out  1  high in DONE.
- step  out  1  one-cycle pulse on each countdown decrement or final expiry.

## Operation
- Each key passes through a 2-flop synchronizer, then the debouncer. A rising edge of the debounced level produces a one-cycle pulse: start_p or pause_p.
- States:
  - IDLE: num=7. start_p → COUNT.
  - COUNT: counts cycles. pause_p → PAUSE.
  - PAUSE: holds the digit and the tick counter. pause_p → COUNT.
  - DONE: num=0. start_p → COUNT.
- Entry to COUNT on start_p: digit←START_VAL, tick_cnt←0. This applies from every state, so start_p in COUNT or PAUSE restarts the game.
- tick_cnt width is $clog2(TICK_DIV). It increments each COUNT cycle. At TICK_DIV-1 it wraps to 0 and asserts step.
  - If digit>0, digit decrements.
  - If digit==0, go to DONE.
- Every digit, including 0, is displayed for exactly TICK_DIV cycles.
- num equals the digit in COUNT and PAUSE.
- Simultaneous start_p and pause_p: start_p wins and pause_p is discarded.
- pause_p in IDLE or DONE is ignored.
- Reset mid-operation: immediate return to IDLE, num=7. Synchronizer and debouncer state are also cleared.

## Timing
- Reset values: num=7, busy=0, done=0, step=0, state=IDLE, digit=START_VAL, tick_cnt=0, debounced levels=0.
- Key latency: a raw level change held stable reaches the debounced level 2+DEB_CYCLES cycles later. The pulse is asserted in that same cycle.
- All outputs are registered. A pulse in cycle N changes state and num at the edge ending cycle N, so they are visible in cycle N+1.
- step is high in the same cycle that the new digit or the DONE state first appears.
- Key bounce shorter than DEB_CYCLES samples produces no pulse.

## Configuration
- COUNT_GAME_BLINK_EN defined:
  - In DONE, num alternates 0 → 7 → 0 every BLINK_DIV cycles, starting with 0 on DONE entry.
  - The blink counter is cleared on DONE entry.
- COUNT_GAME_BLINK_EN undefined:
  - DONE shows a steady 0.
  - No blink counter is synthesized, and BLINK_DIV is unused.

## Structure
- Shared package count_game_pkg:
  - state enum {IDLE, COUNT, PAUSE, DONE}.
  - constant BLANK_CODE=3'd7.
  - constant MAX_DIGIT=3'd6.
- Sub-module key_debounce, parameter DEB_CYCLES. It contains the synchronizer, stable counter and rising-edge pulse. It is instantiated twice.

## Test plan
Bench parameters: TICK_DIV=4, DEB_CYCLES=2, START_VAL=6, BLINK_DIV=3.
- Reset, then idle 20 cycles → num=7, busy=0, done=0, step never asserted.
- Hold key_start 10 cycles → num=6 starting 5 cycles after the press (2 sync + 2 deb + 1). It then steps 5,4,…,0 every 4 cycles with one step pulse per change. DONE with done=1 appears 4 cycles after 0 is first shown.
- During num=4, a key_start glitch of 1 cycle → no effect. Then pause press → num holds 4 for 30 cycles with no step. A second pause press → countdown resumes with the remaining tick count preserved.
- key_start and key_pause pressed on the same cycle while num=3 → restart at num=6 and busy=1, not PAUSE.
- rst asserted during num=2 → num=7, busy=0 immediately, with no clock edge required.
- With COUNT_GAME_BLINK_EN, after DONE → num sequence 0,0,0,7,7,7,0…. Without the macro → num stays 0.
